// File: rtl/wblock_accum.sv
// wblock_accum: vertical accumulator for column-block sums.
// Per-line column-block sums are added over ROWS_PER_BLOCK lines into 2-D
// block weights. Finished weights are tagged with their column and block-row
// indices and queued in a first-word-fall-through FIFO for the packer.
module wblock_accum #(
  parameter int SUM_W          = 8,
  parameter int ACC_W          = 12,
  parameter int BLOCKS_PER_ROW = 4,
  parameter int ROWS_PER_BLOCK = 4,
  parameter int BROW_W         = 4,
  parameter int FIFO_DEPTH     = 8,
  localparam int COL_W = (BLOCKS_PER_ROW > 1) ? $clog2(BLOCKS_PER_ROW) : 1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [COL_W-1:0]  out_col,
  output logic [BROW_W-1:0] out_brow,
  output logic              overflow,
  output logic              fmt_err
);

  // The column counter must be able to hold BLOCKS_PER_ROW itself, which is
  // the "line already full" position used to detect surplus samples.
  localparam int CNT_W  = $clog2(BLOCKS_PER_ROW + 1);
  localparam int LINE_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W  = ACC_W + COL_W + BROW_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  col, col_nxt, cur_col;
  logic [LINE_W-1:0] line, line_nxt, cur_line;
  logic [BROW_W-1:0] brow, brow_nxt, cur_brow;

  logic [ACC_W-1:0]  psum [BLOCKS_PER_ROW];
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  sat_sum;

  logic take, in_range, accept, final_line, err_now;
  logic push, pop, full, push_ok, drop;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]  head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  // A frame_start sample is treated as col 0, line 0 of the new frame, so the
  // counters seen by this cycle's sample are forced to zero.
  assign cur_col  = frame_start ? '0 : col;
  assign cur_line = frame_start ? '0 : line;
  assign cur_brow = frame_start ? '0 : brow;

  assign take       = in_valid & ((state == ACCUM) | frame_start);
  assign in_range   = cur_col < CNT_W'(BLOCKS_PER_ROW);
  assign accept     = take & in_range;
  assign final_line = cur_line == LINE_W'(ROWS_PER_BLOCK - 1);
  assign err_now    = (take & ~in_range) |
                      (take & in_last & (cur_col < CNT_W'(BLOCKS_PER_ROW - 1)));

  // Line 0 starts from zero; later lines add onto the stored partial sum.
  assign base     = (cur_line == '0) ? '0 : psum[cur_col[COL_W-1:0]];
  assign sum_wide = (ACC_W + 1)'(base) + (ACC_W + 1)'(in_sum);
  assign sat_sum  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];

  assign push    = accept & final_line;
  assign pop     = out_valid & out_ready;
  assign full    = count == (PTR_W + 1)'(FIFO_DEPTH);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Next column / line / block-row position after this cycle's sample.
  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    col_nxt  = col;
    line_nxt = line;
    brow_nxt = brow;
    if (frame_start) begin
      col_nxt  = '0;
      line_nxt = '0;
      brow_nxt = '0;
    end
    if (take) begin
      if (in_last) begin
        col_nxt = '0;
        if (final_line) begin
          line_nxt = '0;
          brow_nxt = cur_brow + 1'b1;
        end else begin
          line_nxt = cur_line + 1'b1;
        end
      end else if (in_range) begin
        col_nxt = cur_col + 1'b1;
      end
    end
  end

  // Control FSM with position counters and sticky error flags.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      col      <= '0;
      line     <= '0;
      brow     <= '0;
      overflow <= 1'b0;
      fmt_err  <= 1'b0;
    end else begin
      if (frame_start) state <= ACCUM;
      col      <= col_nxt;
      line     <= line_nxt;
      brow     <= brow_nxt;
      overflow <= (overflow & ~frame_start) | drop;
      fmt_err  <= (fmt_err & ~frame_start) | err_now;
    end
  end

  // Partial-sum RAM, written on every non-final accepted line.
  // NOTE: storage arrays are not reset; line 0 always overwrites before any read, so reset would only cost flops.
  always_ff @(posedge pclk) begin
    if (accept && !final_line) psum[cur_col[COL_W-1:0]] <= sat_sum;
  end

  // Output FIFO storage.
  always_ff @(posedge pclk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {sat_sum, cur_col[COL_W-1:0], cur_brow};
  end

  // Output FIFO pointers and occupancy; a pop frees the slot a full push reuses.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // Head is shown directly (fall-through) and masked to zero while empty.
  assign out_valid = count != '0;
  assign head      = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_data  = head[ENT_W-1 -: ACC_W];
  assign out_col   = head[BROW_W +: COL_W];
  assign out_brow  = head[BROW_W-1:0];

endmodule

// File: tb/tb_wblock_accum.sv
// Directed bench for wblock_accum: default instance plus a 9-bit accumulator
// instance sharing the same stimulus for the saturation case.
module tb_wblock_accum;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_last;
  logic       out_ready;

  logic        out_valid,  out_valid9;
  logic [11:0] out_data;
  logic [8:0]  out_data9;
  logic [1:0]  out_col,    out_col9;
  logic [3:0]  out_brow,   out_brow9;
  logic        overflow,   overflow9;
  logic        fmt_err,    fmt_err9;

  int n_pass  = 0;
  int n_total = 0;

  wblock_accum dut (
    .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start),
    .in_valid(in_valid), .in_sum(in_sum), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_brow(out_brow),
    .overflow(overflow), .fmt_err(fmt_err)
  );

  wblock_accum #(.ACC_W(9)) dut9 (
    .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start),
    .in_valid(in_valid), .in_sum(in_sum), .in_last(in_last),
    .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9),
    .out_col(out_col9), .out_brow(out_brow9),
    .overflow(overflow9), .fmt_err(fmt_err9)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic send(input int fs, input int s, input int l);
    frame_start = (fs != 0);
    in_valid    = 1'b1;
    in_sum      = 8'(s);
    in_last     = (l != 0);
    step();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic send_line(input int s);
    for (int i = 0; i < 4; i++) send(0, s, (i == 3) ? 1 : 0);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0;
    in_sum = 8'd0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid",    32'(out_valid), 0);
    chk("rst_data",     32'(out_data),  0);
    chk("rst_col",      32'(out_col),   0);
    chk("rst_brow",     32'(out_brow),  0);
    chk("rst_overflow", 32'(overflow),  0);
    chk("rst_fmt_err",  32'(fmt_err),   0);
    step();
    rst_n = 1'b1;

    // Basic: 4 lines x 4 blocks of 10
    pulse_frame();
    for (int l = 0; l < 3; l++) send_line(10);
    chk("basic_pre_valid", 32'(out_valid), 0);
    for (int c = 0; c < 4; c++) begin
      send(0, 10, (c == 3) ? 1 : 0);
      chk("basic_valid", 32'(out_valid), 1);
      chk("basic_data",  32'(out_data),  40);
      chk("basic_col",   32'(out_col),   32'(c));
      chk("basic_brow",  32'(out_brow),  0);
    end
    step();
    chk("basic_drained",  32'(out_valid), 0);
    chk("basic_overflow", 32'(overflow),  0);
    chk("basic_fmt_err",  32'(fmt_err),   0);

    // Saturation: 4 x 255 -> 1020 in 12 bits, clamps to 511 in 9 bits
    pulse_frame();
    for (int l = 0; l < 3; l++) send_line(255);
    for (int c = 0; c < 4; c++) begin
      send(0, 255, (c == 3) ? 1 : 0);
      chk("sat9_data", 32'(out_data9), 511);
      chk("sat9_col",  32'(out_col9),  32'(c));
      chk("sat12_data", 32'(out_data), 1020);
    end
    step();
    chk("sat_drained", 32'(out_valid), 0);

    // Backpressure: 12 results into an 8-deep FIFO
    out_ready = 1'b0;
    pulse_frame();
    for (int l = 0; l < 8; l++) send_line(10);
    chk("bp_overflow_at8", 32'(overflow), 0);
    chk("bp_head_valid",   32'(out_valid), 1);
    for (int l = 0; l < 3; l++) send_line(10);
    send(0, 10, 0);
    chk("bp_overflow_at9", 32'(overflow), 1);
    send(0, 10, 0);
    send(0, 10, 0);
    send(0, 10, 1);
    step();
    step();
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_data",  32'(out_data),  40);
    chk("bp_hold_col",   32'(out_col),   0);
    chk("bp_hold_brow",  32'(out_brow),  0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_pop_valid", 32'(out_valid), 1);
      chk("bp_pop_data",  32'(out_data),  40);
      chk("bp_pop_col",   32'(out_col),   32'(k % 4));
      chk("bp_pop_brow",  32'(out_brow),  32'(k / 4));
      step();
    end
    chk("bp_empty", 32'(out_valid), 0);

    // Frame restart with a sample in the same cycle
    send_line(50);
    send_line(50);
    chk("rs_overflow_sticky", 32'(overflow), 1);
    send(1, 1, 0);
    chk("rs_overflow_clr", 32'(overflow), 0);
    chk("rs_fmt_err_clr",  32'(fmt_err),  0);
    send(0, 1, 0);
    send(0, 1, 0);
    send(0, 1, 1);
    send_line(1);
    send_line(1);
    chk("rs_pre_valid", 32'(out_valid), 0);
    for (int c = 0; c < 4; c++) begin
      send(0, 1, (c == 3) ? 1 : 0);
      chk("rs_data", 32'(out_data), 4);
      chk("rs_col",  32'(out_col),  32'(c));
      chk("rs_brow", 32'(out_brow), 0);
    end
    step();

    // Format errors: surplus sample, then a short line
    pulse_frame();
    for (int i = 0; i < 4; i++) send(0, 1, 0);
    chk("fe_no_err_yet", 32'(fmt_err), 0);
    send(0, 1, 0);
    chk("fe_surplus", 32'(fmt_err), 1);
    send(0, 100, 1);
    send(0, 2, 0);
    send(0, 2, 0);
    send(0, 2, 1);
    chk("fe_short_sticky", 32'(fmt_err), 1);
    send_line(4);
    for (int c = 0; c < 4; c++) begin
      send(0, 8, (c == 3) ? 1 : 0);
      chk("fe_data", 32'(out_data), (c == 3) ? 13 : 15);
      chk("fe_col",  32'(out_col),  32'(c));
    end
    step();

    // Reset mid-operation with 3 queued results
    out_ready = 1'b0;
    pulse_frame();
    chk("mr_fmt_err_clr", 32'(fmt_err), 0);
    for (int l = 0; l < 3; l++) send_line(10);
    for (int c = 0; c < 3; c++) send(0, 10, 0);
    chk("mr_valid_before", 32'(out_valid), 1);
    chk("mr_data_before",  32'(out_data),  40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_async", 32'(out_valid), 0);
    chk("mr_data_async",  32'(out_data),  0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      send_line(10);
      chk("mr_idle_valid", 32'(out_valid), 0);
    end
    chk("mr_idle_fmt_err", 32'(fmt_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
